// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential reverse double-dabble BCD-to-binary converter
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_flag_q, err_flag_d;
    logic                done_d;
    logic [BIN_W-1:0]    bin_out_d;
    logic                err_d;

    logic                bad_digit;
    logic [WORK_W-1:0]   shifted;
    logic [WORK_W-1:0]   stepped;
    logic [BCD_W-1:0]    bcd_part;

    // Upper slice of the working register still holding undecoded BCD digits
    assign bcd_part = work_q[WORK_W-1 -: BCD_W];
    assign busy = (state_q == S_CALC);

    // Flag an operand with any digit above 9
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then pull each digit >= 8 down by 3
    always_comb begin
        shifted = work_q >> 1;
        stepped = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i + 3]) begin
                stepped[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and next-output logic; outputs only change on leaving DONE
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        done_d     = 1'b0;
        bin_out_d  = bin_out;
        err_d      = err;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_flag_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        work_d     = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d      = CNT_W'(BIN_W);
                        err_flag_d = 1'b0;
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                work_d = stepped;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                bin_out_d = err_flag_q ? '0 : work_q[BIN_W-1:0];
                err_d     = err_flag_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            done       <= 1'b0;
            bin_out    <= '0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            done       <= done_d;
            bin_out    <= bin_out_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - self-checking bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [15:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int checks;
    int failures;
    bit chk_en;

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal value of a packed BCD word; any digit > 9 marks it invalid
    function automatic void ref_convert(input logic [15:0] v, output logic [BIN_W-1:0] bin, output logic bad);
        int value;
        int d;
        value = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            value = value * 10 + d;
        end
        bin = bad ? '0 : BIN_W'(value);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Timing model: counts down the cycles until done from the accepting edge
    int               m_cnt;
    logic             m_done, m_busy, m_err, p_err;
    logic [BIN_W-1:0] m_bin, p_bin;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_busy = 1'b0;
            m_bin  = '0;
            m_err  = 1'b0;
            p_err  = 1'b0;
            p_bin  = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_bin  = p_bin;
                    m_err  = p_err;
                end
            end else if (start) begin
                ref_convert(bcd_in, p_bin, p_err);
                m_cnt = p_err ? 1 : BIN_W + 1;
            end
            m_busy = (m_cnt >= 2) && !p_err;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("done", done, m_done);
            check("busy", busy, m_busy);
            check("bin_out", bin_out, m_bin);
            check("err", err, m_err);
            if (m_done && !m_err) check("bcd_part_zero", dut.bcd_part, 0);
        end
    end

    task automatic convert(input logic [15:0] v, output int lat, output int busy_cyc);
        bit ok;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = v;
        lat = 0;
        busy_cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            lat++;
            if (busy) busy_cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int lat, bc, dones;
    logic [BIN_W-1:0] mb;
    logic me;

    initial begin
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        bcd_in = '0;

        ref_convert(16'h1234, mb, me);
        check("model_1234", mb, 1234);
        ref_convert(16'h12A4, mb, me);
        check("model_err", me, 1);
        check("model_bcd", to_bcd(9876), 16'h9876);

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin_out, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        convert(16'h0000, lat, bc);
        check("lat_0000", lat, 16);
        check("busy_cyc_0000", bc, 14);
        check("bin_0000", bin_out, 0);
        check("err_0000", err, 0);

        convert(16'h9999, lat, bc);
        check("bin_9999", bin_out, 14'h270F);
        convert(16'h1234, lat, bc);
        check("bin_1234", bin_out, 14'h04D2);

        for (int v = 0; v <= 9999; v += 3) begin
            convert(to_bcd(v), lat, bc);
            if (bin_out !== BIN_W'(v)) check("sweep_bin", bin_out, v);
        end

        convert(16'h12A4, lat, bc);
        check("lat_err", lat, 2);
        check("busy_cyc_err", bc, 0);
        check("err_12A4", err, 1);
        check("bin_12A4", bin_out, 0);
        convert(16'h0042, lat, bc);
        check("err_0042", err, 0);
        check("bin_0042", bin_out, 42);

        // Extra start pulses in CALC and in the DONE state cycle must be ignored
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h5678;
        dones = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) dones++;
            case (i)
                1: start = 1'b0;
                4: begin start = 1'b1; bcd_in = 16'h0001; end
                5: start = 1'b0;
                15: begin start = 1'b1; bcd_in = 16'h0001; end
                16: start = 1'b0;
                default: ;
            endcase
        end
        check("ignore_dones", dones, 1);
        check("ignore_bin", bin_out, 5678);

        // Reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bcd_in = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_dones", dones, 0);
        check("abort_busy", busy, 0);
        check("abort_bin", bin_out, 0);
        convert(16'h0007, lat, bc);
        check("bin_0007", bin_out, 7);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
